// File: rtl/poly_downsample_slicer.sv
// Symbol-rate slicer placed after the polyphase FIR: counts sample phase and emits
// one sign decision per channel per symbol, with phase changes deferred to symbol boundaries.
module poly_downsample_slicer #(
  parameter int NB_DATA    = 8,
  parameter int N_OVERSAMP = 4,
  parameter int NB_PHASE   = 2,
  parameter int N_CH       = 2
) (
  input  logic                      clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [N_CH*NB_DATA-1:0]   i_data,
  input  logic [NB_PHASE-1:0]       i_sel_phase,
  output logic [N_CH-1:0]           o_bit,
  output logic                      o_valid,
  output logic                      o_reset_sinc,
  output logic [NB_PHASE-1:0]       o_phase
);

  localparam int                  CNT_W    = (N_OVERSAMP > 1) ? $clog2(N_OVERSAMP) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(N_OVERSAMP - 1);
  localparam logic [NB_PHASE:0]   N_OS_EXT = (NB_PHASE + 1)'(N_OVERSAMP);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NB_PHASE-1:0] phase_act_q, phase_act_d;
  logic [NB_PHASE-1:0] pend_val_q, pend_val_d;
  logic                pend_flag_q, pend_flag_d;
  logic [N_CH-1:0]     bit_q, bit_d;
  logic                valid_q, valid_d;
  logic                sinc_q, sinc_d;

  logic is_last;
  logic is_decision;
  logic apply;
  logic sel_in_range;

  always_comb begin
    cnt_d        = cnt_q;
    phase_act_d  = phase_act_q;
    pend_val_d   = pend_val_q;
    pend_flag_d  = pend_flag_q;
    bit_d        = bit_q;
    valid_d      = 1'b0;
    sinc_d       = 1'b0;

    is_last      = (cnt_q == CNT_LAST);
    is_decision  = (NB_PHASE'(cnt_q) == phase_act_q);
    apply        = i_enable && is_last && pend_flag_q;
    sel_in_range = ({1'b0, i_sel_phase} < N_OS_EXT);

    if (i_enable) begin
      cnt_d = is_last ? '0 : cnt_q + CNT_W'(1);
      if (is_decision) begin
        valid_d = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
          bit_d[k] = i_data[k*NB_DATA + NB_DATA - 1];
        end
      end
    end

    // The decision above still used the old phase; the new one takes effect next symbol.
    if (apply) begin
      phase_act_d = pend_val_q;
      pend_flag_d = 1'b0;
      sinc_d      = 1'b1;
    end

    // Requests compare against the phase that will be active after this edge, so a
    // request arriving on an apply edge waits for the following boundary.
    if (sel_in_range) begin
      if (i_sel_phase == phase_act_d) begin
        pend_flag_d = 1'b0;
      end else begin
        pend_val_d  = i_sel_phase;
        pend_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q       <= '0;
      phase_act_q <= '0;
      pend_val_q  <= '0;
      pend_flag_q <= 1'b0;
      bit_q       <= '0;
      valid_q     <= 1'b0;
      sinc_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_act_q <= phase_act_d;
      pend_val_q  <= pend_val_d;
      pend_flag_q <= pend_flag_d;
      bit_q       <= bit_d;
      valid_q     <= valid_d;
      sinc_q      <= sinc_d;
    end
  end

  assign o_bit        = bit_q;
  assign o_valid      = valid_q;
  assign o_reset_sinc = sinc_q;
  assign o_phase      = phase_act_q;

endmodule

// File: tb/tb_poly_downsample_slicer.sv
// Self-checking bench for poly_downsample_slicer: directed steps plus random stimulus,
// compared every cycle against a symbol-level reference model.
module tb_poly_downsample_slicer;

   localparam int NB_DATA    = 8;
   localparam int N_OVERSAMP = 4;
   localparam int NB_PHASE   = 3;
   localparam int N_CH       = 2;

   logic                    clock = 1'b0;
   logic                    i_reset;
   logic                    i_enable;
   logic [N_CH*NB_DATA-1:0] i_data;
   logic [NB_PHASE-1:0]     i_sel_phase;
   logic [N_CH-1:0]         o_bit;
   logic                    o_valid;
   logic                    o_reset_sinc;
   logic [NB_PHASE-1:0]     o_phase;

   int errors = 0;
   int checks = 0;

   // Reference model state: position inside the symbol, active phase, pending request
   int              mPos;
   int              mAct;
   int              mPendVal;
   bit              mPend;
   logic            expValid;
   logic            expSinc;
   logic [N_CH-1:0] expBit;

   poly_downsample_slicer #(
      .NB_DATA    (NB_DATA),
      .N_OVERSAMP (N_OVERSAMP),
      .NB_PHASE   (NB_PHASE),
      .N_CH       (N_CH)
   ) dut (
      .clock        (clock),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_data       (i_data),
      .i_sel_phase  (i_sel_phase),
      .o_bit        (o_bit),
      .o_valid      (o_valid),
      .o_reset_sinc (o_reset_sinc),
      .o_phase      (o_phase)
   );

   always #5 clock = ~clock;

   // Clears the model exactly as an asynchronous reset clears the slicer
   task automatic modelReset();
      mPos     = 0;
      mAct     = 0;
      mPendVal = 0;
      mPend    = 0;
      expValid = 1'b0;
      expSinc  = 1'b0;
      expBit   = '0;
   endtask

   // Predicts the outputs that follow the coming clock edge from the inputs now applied
   task automatic modelStep();
      logic signed [NB_DATA-1:0] sample;
      int                        newAct;
      bit                        boundaryApply;
      if (!i_reset) begin
         modelReset();
         return;
      end
      expValid = 1'b0;
      expSinc  = 1'b0;
      if (i_enable && mPos == mAct) begin
         expValid = 1'b1;
         for (int k = 0; k < N_CH; k++) begin
            sample    = i_data[k*NB_DATA +: NB_DATA];
            expBit[k] = (sample < 0);
         end
      end
      boundaryApply = i_enable && (mPos == N_OVERSAMP - 1) && mPend;
      newAct = boundaryApply ? mPendVal : mAct;
      if (boundaryApply) begin
         mPend   = 0;
         expSinc = 1'b1;
      end
      if (int'(i_sel_phase) < N_OVERSAMP) begin
         if (int'(i_sel_phase) == newAct) begin
            mPend = 0;
         end else begin
            mPend    = 1;
            mPendVal = int'(i_sel_phase);
         end
      end
      mAct = newAct;
      if (i_enable) mPos = (mPos + 1) % N_OVERSAMP;
   endtask

   // Drives one cycle of inputs, advances the model, and lands #1 after the active edge
   task automatic applyStimulus(input logic en, input logic [N_CH*NB_DATA-1:0] data,
                                input logic [NB_PHASE-1:0] sel);
      i_enable    = en;
      i_data      = data;
      i_sel_phase = sel;
      modelStep();
      @(posedge clock);
      #1;
   endtask

   // Compares every output against the model prediction
   task automatic checkOutput(input string tag);
      checks++;
      assert (o_valid === expValid) else begin
         errors++;
         $error("[TB] FAIL %s o_valid observed=%0b expected=%0b", tag, o_valid, expValid);
      end
      checks++;
      assert (o_bit === expBit) else begin
         errors++;
         $error("[TB] FAIL %s o_bit observed=%b expected=%b", tag, o_bit, expBit);
      end
      checks++;
      assert (o_reset_sinc === expSinc) else begin
         errors++;
         $error("[TB] FAIL %s o_reset_sinc observed=%0b expected=%0b", tag, o_reset_sinc, expSinc);
      end
      checks++;
      assert (int'(o_phase) === mAct) else begin
         errors++;
         $error("[TB] FAIL %s o_phase observed=%0d expected=%0d", tag, o_phase, mAct);
      end
   endtask

   // Single linear sequence of directed steps followed by random traffic
   initial begin
      logic [N_CH*NB_DATA-1:0] pattern [4];
      logic [NB_PHASE-1:0]     sel;
      bit                      found;
      pattern[0] = 16'h7F80;
      pattern[1] = 16'h9010;
      pattern[2] = 16'h9010;
      pattern[3] = 16'h9010;

      i_reset     = 1'b0;
      i_enable    = 1'b0;
      i_data      = '0;
      i_sel_phase = '0;
      modelReset();
      #12;
      checkOutput("reset");
      @(posedge clock);
      #1;
      i_reset = 1'b1;

      $display("[TB] plain slicing at phase 0");
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, pattern[c % 4], 3'd0);
         checkOutput("plain");
         if (c % 4 == 0) begin
            checks++;
            assert (o_valid === 1'b1 && o_bit === 2'b01) else begin
               errors++;
               $error("[TB] FAIL plainFixed valid/bit observed=%0b/%b expected=1/01", o_valid, o_bit);
            end
         end
      end

      $display("[TB] phase change 0 to 2 mid-symbol");
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b1, 16'($urandom), (c >= 1) ? 3'd2 : 3'd0);
         checkOutput("change02");
      end

      $display("[TB] request arriving on the boundary edge");
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, 16'($urandom), 3'd3);
         checkOutput("goto3");
      end
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b1, 16'($urandom), (c < 3) ? 3'd3 : 3'd1);
         checkOutput("deferred");
      end

      $display("[TB] gapped enable");
      for (int c = 0; c < 20; c++) begin
         applyStimulus((c % 2) == 0, 16'($urandom), 3'd1);
         checkOutput("gapped");
      end

      $display("[TB] cancelled request and out-of-range selects");
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, 16'($urandom), 3'd0);
         checkOutput("back0");
      end
      for (int c = 0; c < 3; c++) begin
         sel = (c == 0) ? 3'd2 : ((c == 1) ? 3'd3 : 3'd0);
         applyStimulus(1'b1, 16'($urandom), sel);
         checkOutput("cancel");
      end
      for (int c = 0; c < 9; c++) begin
         applyStimulus(1'b1, 16'($urandom), 3'(4 + (c % 4)));
         checkOutput("outrange");
      end
      checks++;
      assert (o_phase === 3'd0 && o_reset_sinc === 1'b0) else begin
         errors++;
         $error("[TB] FAIL ignoredSel phase/sinc observed=%0d/%0b expected=0/0", o_phase, o_reset_sinc);
      end

      $display("[TB] random traffic");
      sel = 3'd0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 5) == 0) sel = 3'($urandom_range(0, 7));
         applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), sel);
         checkOutput("random");
      end

      $display("[TB] reset while o_valid is high");
      found = 0;
      for (int c = 0; c < 16 && !found; c++) begin
         applyStimulus(1'b1, 16'($urandom), 3'd0);
         checkOutput("preReset");
         if (o_valid === 1'b1) found = 1;
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("[TB] FAIL validWait observed=timeout expected=o_valid within 16 cycles");
      end
      #2;
      i_reset = 1'b0;
      #1;
      modelReset();
      checkOutput("midReset");
      @(posedge clock);
      #1;
      checkOutput("heldReset");
      i_reset = 1'b1;
      applyStimulus(1'b1, 16'h00F0, 3'd0);
      checkOutput("firstAfterReset");
      checks++;
      assert (o_valid === 1'b1 && o_bit === 2'b01) else begin
         errors++;
         $error("[TB] FAIL firstFixed valid/bit observed=%0b/%b expected=1/01", o_valid, o_bit);
      end
      for (int c = 0; c < 7; c++) begin
         applyStimulus(1'b1, 16'($urandom), 3'd0);
         checkOutput("afterReset");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
